// File: rtl/card_pkg.sv
// Shared definitions for the card pipeline: frame geometry, coordinate widths
// and the corner extractor FSM state type.
package card_pkg;

  localparam int unsigned FRAME_WIDTH  = 240;
  localparam int unsigned FRAME_HEIGHT = 320;
  localparam int unsigned ADDR_W       = 17;
  localparam int unsigned X_W          = 8;
  localparam int unsigned Y_W          = 9;
  localparam int unsigned PIX_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] left;
    logic [X_W-1:0] right;
    logic [Y_W-1:0] top;
    logic [Y_W-1:0] bot;
  } box_t;

endpackage

// File: rtl/corner_extractor_if.sv
// Box request, frame-buffer read port and corner pixel stream of the corner extractor.
interface corner_extractor_if;
  import card_pkg::*;

  logic             start_in;
  logic [X_W-1:0]   left_edge;
  logic [X_W-1:0]   right_edge;
  logic [Y_W-1:0]   top_edge;
  logic [Y_W-1:0]   bot_edge;
  logic [PIX_W-1:0] pixel_data_in;
  logic [ADDR_W-1:0] addr_out;
  logic [PIX_W-1:0] pixel_out;
  logic             pixel_valid_out;
  logic             pixel_last_out;
  logic [X_W-1:0]   corner_width;
  logic [Y_W-1:0]   corner_height;
  logic             busy_out;
  logic             done_out;
  logic             err_out;

  modport slave (
    input  start_in, left_edge, right_edge, top_edge, bot_edge, pixel_data_in,
    output addr_out, pixel_out, pixel_valid_out, pixel_last_out,
           corner_width, corner_height, busy_out, done_out, err_out
  );

  modport master (
    output start_in, left_edge, right_edge, top_edge, bot_edge, pixel_data_in,
    input  addr_out, pixel_out, pixel_valid_out, pixel_last_out,
           corner_width, corner_height, busy_out, done_out, err_out
  );

endinterface

// File: rtl/latency_tag_pipe.sv
// Shift register carrying {valid, last} tags alongside frame-buffer reads so they
// emerge in the same cycle as the matching read data.
module latency_tag_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;
  logic [DEPTH:0]   valid_shift;
  logic [DEPTH:0]   last_shift;

  // Stage 0 of the shift view is the incoming tag, so DEPTH=1 needs no special case.
  assign valid_shift = {valid_q, valid_i};
  assign last_shift  = {last_q, last_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_shift[DEPTH-1:0];
      last_q  <= last_shift[DEPTH-1:0];
    end
  end

  assign valid_o = valid_shift[DEPTH];
  assign last_o  = last_shift[DEPTH];

endmodule

// File: rtl/corner_extractor.sv
// Latches a card bounding box, derives the top-left corner window and raster-scans
// it through the frame-buffer read port as a valid/last qualified pixel stream.
module corner_extractor
  import card_pkg::*;
#(
  parameter int unsigned WIDTH        = FRAME_WIDTH,
  parameter int unsigned HEIGHT       = FRAME_HEIGHT,
  parameter int unsigned CW_SHIFT     = 2,
  parameter int unsigned CH_SHIFT     = 2,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  corner_extractor_if.slave bus
);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH);

  state_e            state_q, state_d;
  box_t              box_q, box_d;
  logic [X_W-1:0]    cw_q, cw_d;
  logic [Y_W-1:0]    ch_q, ch_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    row_q, row_d;

  logic [X_W:0]      span_x, cw_raw;
  logic [Y_W:0]      span_y, ch_raw;
  logic [X_W-1:0]    cw_sat, x_end;
  logic [Y_W-1:0]    ch_sat;
  logic [ADDR_W-1:0] top_base, row_next;
  logic              box_ok, last_col, last_row, issue, last_issue;
  logic              tag_valid, tag_last;

  assign span_x = {1'b0, box_q.right} - {1'b0, box_q.left} + (X_W+1)'(1);
  assign span_y = {1'b0, box_q.bot} - {1'b0, box_q.top} + (Y_W+1)'(1);
  assign cw_raw = span_x >> CW_SHIFT;
  assign ch_raw = span_y >> CH_SHIFT;
  assign cw_sat = (cw_raw == '0) ? X_W'(1) : cw_raw[X_W-1:0];
  assign ch_sat = (ch_raw == '0) ? Y_W'(1) : ch_raw[Y_W-1:0];

  assign box_ok = (box_q.right > box_q.left) && (box_q.bot > box_q.top) &&
                  (32'(box_q.right) < WIDTH) && (32'(box_q.bot) < HEIGHT);

  // Single multiply per box; rows afterwards advance by adding the stride.
  assign top_base = ADDR_W'(box_q.top) * ROW_STRIDE;
  assign row_next = row_base_q + ROW_STRIDE;

  assign x_end      = box_q.left + cw_q - X_W'(1);
  assign last_col   = (x_q == x_end);
  assign last_row   = (row_q == ch_q - Y_W'(1));
  assign issue      = (state_q == ST_SCAN);
  assign last_issue = issue && last_col && last_row;

  always_comb begin
    state_d    = state_q;
    box_d      = box_q;
    cw_d       = cw_q;
    ch_d       = ch_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    x_d        = x_q;
    row_d      = row_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          box_d.left  = bus.left_edge;
          box_d.right = bus.right_edge;
          box_d.top   = bus.top_edge;
          box_d.bot   = bus.bot_edge;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (box_ok) begin
          cw_d       = cw_sat;
          ch_d       = ch_sat;
          row_base_d = top_base;
          addr_d     = top_base + ADDR_W'(box_q.left);
          x_d        = box_q.left;
          row_d      = '0;
          state_d    = ST_SCAN;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_SCAN: begin
        if (last_col && last_row) begin
          state_d = ST_DRAIN;
        end else if (last_col) begin
          row_base_d = row_next;
          addr_d     = row_next + ADDR_W'(box_q.left);
          x_d        = box_q.left;
          row_d      = row_q + Y_W'(1);
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          x_d    = x_q + X_W'(1);
        end
      end
      ST_DRAIN: begin
        if (tag_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      box_q      <= '0;
      cw_q       <= '0;
      ch_q       <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      x_q        <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      box_q      <= box_d;
      cw_q       <= cw_d;
      ch_q       <= ch_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      row_q      <= row_d;
    end
  end

  latency_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tags (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .valid_i(issue),
    .last_i (last_issue),
    .valid_o(tag_valid),
    .last_o (tag_last)
  );

  assign bus.addr_out        = addr_q;
  assign bus.pixel_out       = tag_valid ? bus.pixel_data_in : '0;
  assign bus.pixel_valid_out = tag_valid;
  assign bus.pixel_last_out  = tag_last;
  assign bus.corner_width    = cw_q;
  assign bus.corner_height   = ch_q;
  assign bus.busy_out        = (state_q == ST_SETUP) || (state_q == ST_SCAN) ||
                               (state_q == ST_DRAIN);
  assign bus.done_out        = (state_q == ST_DONE);
  assign bus.err_out         = (state_q == ST_ERR);

endmodule

// File: tb/tb_corner_extractor.sv
// Directed bench for corner_extractor: three instances at read latencies 1, 2 and 3
// share one box stimulus; instance 2 is the primary checked design.
module tb_corner_extractor;

  typedef struct {
    int l, r, t, b;
    int cw, ch;
    int first_addr, last_addr;
    int count, last_rel, done_rel, err_rel;
  } vec_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] le      = '0;
  logic [7:0] re      = '0;
  logic [8:0] te      = '0;
  logic [8:0] be      = '0;
  logic       mon_clr = 1'b0;
  int cyc = 0, start_cyc = 0;
  int exp_left = 0, exp_top = 0, exp_cw = 1;
  int n_tests = 0, n_fail = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synthetic frame content, distinct for every address inside a corner window.
  function automatic logic [15:0] mem_f(input logic [16:0] a);
    logic [16:0] t;
    t = (a * 17'd13) ^ 17'h0AC35;
    return t[15:0] ^ {15'd0, t[16]};
  endfunction

  function automatic logic [15:0] exp_pix(input int k);
    int ea;
    ea = (exp_top + k / exp_cw) * 240 + exp_left + k % exp_cw;
    return mem_f(17'(ea));
  endfunction

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    corner_extractor_if bus ();
    logic [15:0] rd_pipe [g];
    logic [16:0] first_addr;
    int rel, vcnt, first_rel, last_rel, last_idx, done_rel, err_rel, done_cnt, busy_cnt, data_err;

    assign rel               = cyc - start_cyc;
    assign bus.start_in      = start;
    assign bus.left_edge     = le;
    assign bus.right_edge    = re;
    assign bus.top_edge      = te;
    assign bus.bot_edge      = be;
    assign bus.pixel_data_in = rd_pipe[g-1];

    corner_extractor #(
      .READ_LATENCY(g)
    ) dut (
      .clk_in(clk),
      .rst_in(rst_n),
      .bus   (bus)
    );

    always @(posedge clk) begin
      rd_pipe[0] <= mem_f(bus.addr_out);
      for (int i = 1; i < g; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    always @(negedge clk) begin
      if (mon_clr) begin
        vcnt <= 0; first_rel <= -1; last_rel <= -1; last_idx <= -1;
        done_rel <= -1; err_rel <= -1; done_cnt <= 0; busy_cnt <= 0;
        data_err <= 0; first_addr <= '0;
      end else begin
        if (rel == 2) first_addr <= bus.addr_out;
        if (bus.busy_out) busy_cnt <= busy_cnt + 1;
        if (bus.pixel_valid_out) begin
          vcnt <= vcnt + 1;
          if (first_rel < 0) first_rel <= rel;
          if (bus.pixel_out != exp_pix(vcnt)) data_err <= data_err + 1;
          if (bus.pixel_last_out) begin
            last_rel <= rel;
            last_idx <= vcnt + 1;
          end
        end else if (bus.pixel_last_out) begin
          data_err <= data_err + 1;
        end
        if (bus.done_out) begin
          done_cnt <= done_cnt + 1;
          done_rel <= rel;
        end
        if (bus.err_out) err_rel <= rel;
      end
    end
  end

  function automatic longint main_outs();
    return longint'({g_dut[2].bus.pixel_out, g_dut[2].bus.pixel_valid_out,
                     g_dut[2].bus.pixel_last_out, g_dut[2].bus.addr_out,
                     g_dut[2].bus.corner_width, g_dut[2].bus.corner_height,
                     g_dut[2].bus.busy_out, g_dut[2].bus.done_out, g_dut[2].bus.err_out});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input int l, input int r, input int t, input int b, input int cw);
    clear_mon();
    exp_left  = l;
    exp_top   = t;
    exp_cw    = (cw > 0) ? cw : 1;
    le        = 8'(l);
    re        = 8'(r);
    te        = 9'(t);
    be        = 9'(b);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 6000 && !seen; n++) begin
      tick();
      if (g_dut[2].done_rel >= 0 || g_dut[2].err_rel >= 0) seen = 1'b1;
    end
    check({name, "_finished"}, longint'(seen), 1);
    repeat (6) tick();
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    string p;
    v = vecs[i];
    p = $sformatf("v%0d_", i);
    pulse_start(v.l, v.r, v.t, v.b, v.cw);
    wait_end({p, "run"});
    check({p, "err_rel"},  g_dut[2].err_rel,  v.err_rel);
    check({p, "done_rel"}, g_dut[2].done_rel, v.done_rel);
    check({p, "count"},    g_dut[2].vcnt,     v.count);
    check({p, "last_rel"}, g_dut[2].last_rel, v.last_rel);
    check({p, "last_idx"}, g_dut[2].last_idx, (v.count > 0) ? v.count : -1);
    check({p, "busy_cycles"}, g_dut[2].busy_cnt, (v.err_rel > 0) ? 1 : v.last_rel);
    check({p, "data"},     g_dut[2].data_err, 0);
    if (v.cw > 0) begin
      check({p, "cw"},         g_dut[2].bus.corner_width,  v.cw);
      check({p, "ch"},         g_dut[2].bus.corner_height, v.ch);
      check({p, "first_addr"}, g_dut[2].first_addr,        v.first_addr);
      check({p, "last_addr"},  g_dut[2].bus.addr_out,      v.last_addr);
    end
    check({p, "lat1_first"}, g_dut[1].first_rel, (v.count > 0) ? 3 : -1);
    check({p, "lat3_first"}, g_dut[3].first_rel, (v.count > 0) ? 5 : -1);
    check({p, "lat1_count"}, g_dut[1].vcnt, v.count);
    check({p, "lat3_count"}, g_dut[3].vcnt, v.count);
    check({p, "lat1_data"},  g_dut[1].data_err, 0);
    check({p, "lat3_data"},  g_dut[3].data_err, 0);
    check({p, "lat1_done"},  g_dut[1].done_rel, (v.count > 0) ? v.done_rel - 1 : -1);
    check({p, "lat3_done"},  g_dut[3].done_rel, (v.count > 0) ? v.done_rel + 1 : -1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          l    r    t    b   cw  ch  first  last   cnt  lastc done  err
    vecs[0] = '{ 40, 199,  30, 289, 40, 65,  7240, 22639, 2600, 2603, 2604, -1};
    vecs[1] = '{100, 100,  30, 289, -1, -1,    -1,    -1,    0,   -1,   -1,  2};
    vecs[2] = '{ 40, 199,  30, 320, -1, -1,    -1,    -1,    0,   -1,   -1,  2};
    vecs[3] = '{ 10,  12,   5,   6,  1,  1,  1210,  1210,    1,    4,    5, -1};
    vecs[4] = '{  0, 239,   0, 319, 60, 80,     0, 19019, 4800, 4803, 4804, -1};
    vecs[5] = '{ 10,  50, 100,  90, -1, -1,    -1,    -1,    0,   -1,   -1,  2};
    vecs[6] = '{ 10, 240,   0,  10, -1, -1,    -1,    -1,    0,   -1,   -1,  2};
    vecs[7] = '{  3,  10,   7,  14,  2,  2,  1683,  1924,    4,    7,    8, -1};

    repeat (3) tick();
    @(negedge clk);
    #1;
    check("reset_outputs", main_outs(), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Second start with a different box while the first scan is running.
    pulse_start(40, 199, 30, 289, 40);
    repeat (100) tick();
    le = 8'd10; re = 8'd12; te = 9'd5; be = 9'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end("midstart");
    check("midstart_count",     g_dut[2].vcnt,              2600);
    check("midstart_done_rel",  g_dut[2].done_rel,          2604);
    check("midstart_last_rel",  g_dut[2].last_rel,          2603);
    check("midstart_first",     g_dut[2].first_addr,        7240);
    check("midstart_last_addr", g_dut[2].bus.addr_out,      22639);
    check("midstart_cw",        g_dut[2].bus.corner_width,  40);
    check("midstart_ch",        g_dut[2].bus.corner_height, 65);
    check("midstart_data",      g_dut[2].data_err,          0);

    // Reset lands during the 500th streamed pixel of the large box.
    pulse_start(40, 199, 30, 289, 40);
    while (cyc - start_cyc < 503) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    #1;
    check("rst_mid_outputs", main_outs(), 0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("rst_mid_count",   g_dut[2].vcnt,     500);
    check("rst_mid_done",    g_dut[2].done_cnt, 0);
    check("rst_mid_data",    g_dut[2].data_err, 0);
    check("rst_mid_idle",    main_outs(),       0);

    run_vec(0);
    run_vec(7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
